serial_add_ctrl: RTL and testbench

//   Bit-serial add controller. Sequences one 1-bit CMOS full-adder cell over a WIDTH-bit operand pair, LSB first.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/fa_bit.sv | 40 ++++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add controller.
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

   // Controller states, fixed 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter width that can hold WIDTH-1 without wrapping inside an op.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/fa_bit.sv
// 1-bit full adder cell built from switch-level CMOS devices.
// A transmission-gate style cell: inverters for the complemented inputs,
// then complementary nmos/pmos pass pairs acting as 2:1 muxes.
//   p  = a ^ b            (a ? ~b : b)
//   s  = p ^ ci           (p ? ~ci : ci)
//   co = p ? ci : a       (generate when a==b, propagate otherwise)
module fa_bit (
   input  wire a,
   input  wire b,
   input  wire ci,
   output wire s,
   output wire co
);

   supply1 vdd;
   supply0 gnd;

   wire b_n;
   wire ci_n;
   wire p;

   // Static CMOS inverters.
   pmos (b_n, vdd, b);
   nmos (b_n, gnd, b);
   pmos (ci_n, vdd, ci);
   nmos (ci_n, gnd, ci);

   // Propagate: a=1 passes ~b, a=0 passes b.
   nmos (p, b_n, a);
   pmos (p, b, a);

   // Sum: p=1 passes ~ci, p=0 passes ci.
   nmos (s, ci_n, p);
   pmos (s, ci, p);

   // Carry: p=1 propagates ci, p=0 generates/kills with a (a==b).
   nmos (co, ci, p);
   pmos (co, a, p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: one shared full-adder cell sequenced LSB first
// over a WIDTH-bit operand pair, with valid/ready on both sides.
// Define SERIAL_ADD_SUB_EN to add the `sub` port (a - b - ~cin mode).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] next_res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last_bit;

   wire              cell_s;
   wire              cell_co;

   // The single shared adder cell.
   fa_bit u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode, handshake outputs and next result word.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      next_state = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      next_res   = res_sr >> 1;
      next_res[WIDTH-1] = cell_s;
      accept     = 1'b0;
      last_bit   = (cnt == LAST_CNT);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) next_state = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) next_state = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (out_valid && out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, one bit per SHIFT cycle, and result/valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            a_sr  <= a;
`ifdef SERIAL_ADD_SUB_EN
            b_sr  <= sub ? ~b : b;
`else
            b_sr  <= b;
`endif
            carry <= cin;
            cnt   <= '0;
         end
         if (state == SHIFT) begin
            carry  <= cell_co;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= next_res;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
               sum       <= next_res;
               cout      <= cell_co;
               out_valid <= 1'b1;
            end
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Covers SERIAL_ADD_SUB_EN when that macro is defined for the build.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair from IDLE; returns just after the accept edge.
   task automatic offer(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_before_offer", in_ready, 1'b1);
      a = av;
      b = bv;
      cin = cv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'hA5;
      b = 8'h5A;
      cin = 1'b0;
   endtask

   // Cycles from the accept edge until out_valid is seen (0 if it never rises).
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_after_take", out_valid, 1'b0);
      check("in_ready_after_take", in_ready, 1'b1);
   endtask

   initial begin
      logic [W-1:0] ops_a [3];
      logic [W-1:0] ops_b [3];
      logic         ops_c [3];
      logic [W-1:0] exp_s [3];
      logic         exp_c [3];
      int           vcyc  [3];
      int           lat;
      int           next_op;
      int           res_idx;

      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif

      // Reset state.
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sum", sum, 8'h00);
      check("rst_cout", cout, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", in_ready, 1'b1);
      check("rel_busy", busy, 1'b0);

      // Basic add with latency.
      offer(8'h5A, 8'h3C, 1'b0);
      check("basic_busy", busy, 1'b1);
      check("basic_in_ready", in_ready, 1'b0);
      wait_valid(lat);
      check("basic_latency", lat, 8);
      check("basic_sum", sum, 8'h96);
      check("basic_cout", cout, 1'b0);
      take_result();

      // Carry ripple.
      offer(8'hFF, 8'h01, 1'b0);
      wait_valid(lat);
      check("ripple1_latency", lat, 8);
      check("ripple1_sum", sum, 8'h00);
      check("ripple1_cout", cout, 1'b1);
      take_result();
      offer(8'hFF, 8'hFF, 1'b1);
      wait_valid(lat);
      check("ripple2_sum", sum, 8'hFF);
      check("ripple2_cout", cout, 1'b1);
      take_result();

      // Backpressure: result held, in_valid pulses ignored.
      offer(8'h12, 8'h34, 1'b1);
      wait_valid(lat);
      check("bp_latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 8'h77;
         b = 8'h66;
         tick();
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_sum", sum, 8'h47);
         check("bp_cout", cout, 1'b0);
         check("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      take_result();
      check("bp_idle_busy", busy, 1'b0);
      check("bp_sum_kept", sum, 8'h47);

      // Reset in the middle of SHIFT.
      offer(8'h77, 8'h11, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_sum", sum, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      offer(8'h01, 8'h02, 1'b0);
      wait_valid(lat);
      check("post_abort_latency", lat, 8);
      check("post_abort_sum", sum, 8'h03);
      check("post_abort_cout", cout, 1'b0);
      take_result();

      // Back-to-back with out_ready held high.
      ops_a[0] = 8'h80; ops_b[0] = 8'h80; ops_c[0] = 1'b0; exp_s[0] = 8'h00; exp_c[0] = 1'b1;
      ops_a[1] = 8'h0F; ops_b[1] = 8'hF0; ops_c[1] = 1'b0; exp_s[1] = 8'hFF; exp_c[1] = 1'b0;
      ops_a[2] = 8'hC3; ops_b[2] = 8'h25; ops_c[2] = 1'b1; exp_s[2] = 8'hE9; exp_c[2] = 1'b0;
      out_ready = 1'b1;
      next_op = 0;
      res_idx = 0;
      for (int k = 0; k < 80 && res_idx < 3; k++) begin
         if (out_valid) begin
            check("b2b_sum", sum, exp_s[res_idx]);
            check("b2b_cout", cout, exp_c[res_idx]);
            vcyc[res_idx] = cyc;
            res_idx++;
         end
         if (in_ready && next_op < 3) begin
            a = ops_a[next_op];
            b = ops_b[next_op];
            cin = ops_c[next_op];
            in_valid = 1'b1;
            next_op++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", res_idx, 3);
      if (res_idx == 3) begin
         check("b2b_period_1", vcyc[1] - vcyc[0], W + 2);
         check("b2b_period_2", vcyc[2] - vcyc[1], W + 2);
      end
      tick();

`ifdef SERIAL_ADD_SUB_EN
      // Subtract mode.
      sub = 1'b1;
      offer(8'h10, 8'h01, 1'b1);
      sub = 1'b0;
      wait_valid(lat);
      check("sub1_sum", sum, 8'h0F);
      check("sub1_cout", cout, 1'b1);
      take_result();
      sub = 1'b1;
      offer(8'h00, 8'h01, 1'b1);
      sub = 1'b0;
      wait_valid(lat);
      check("sub2_sum", sum, 8'hFF);
      check("sub2_cout", cout, 1'b0);
      take_result();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
